// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input pattern of a combinational
// block, waits SETTLE cycles, then either streams the response or compares it
// with a reference and accumulates error statistics.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned N_OUT  = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  output logic [N_IN-1:0]                pi,
  input  logic [N_OUT-1:0]               po_dut,
  input  logic [N_OUT-1:0]               po_ref,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_IN-1:0]                out_pattern,
  output logic [N_OUT-1:0]               out_value,
  output logic                           busy,
  output logic                           done,
  output logic [N_IN:0]                  err_count,
  output logic [$clog2(N_OUT+1)-1:0]     err_hd_max,
  output logic [N_IN+N_OUT-1:0]          err_abs_sum
);

  localparam int unsigned HD_W  = $clog2(N_OUT + 1);
  localparam int unsigned SUM_W = N_IN + N_OUT;
  localparam int unsigned ERR_W = N_IN + 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   settle_cnt;
  logic               mode_q;

  logic               load_start_c;
  logic               sample_stream_c;
  logic               sample_cmp_c;
  logic               advance_c;
  logic               last_pat_c;

  logic [N_OUT-1:0]   diff_c;
  logic [N_OUT-1:0]   abs_diff_c;
  logic [HD_W-1:0]    hd_c;

  // Hamming weight of the response difference
  function automatic logic [HD_W-1:0] popcount(input logic [N_OUT-1:0] v);
    logic [HD_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      c = c + HD_W'(v[i]);
    end
    return c;
  endfunction

  // Compare-mode metrics for the current pattern
  always_comb begin
    diff_c     = po_dut ^ po_ref;
    hd_c       = popcount(diff_c);
    abs_diff_c = (po_dut >= po_ref) ? (po_dut - po_ref) : (po_ref - po_dut);
    last_pat_c = (pi == {N_IN{1'b1}});
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nx        = state;
    load_start_c    = 1'b0;
    sample_stream_c = 1'b0;
    sample_cmp_c    = 1'b0;
    advance_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_start_c = 1'b1;
          state_nx     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == CNT_W'(1)) begin
          state_nx = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (mode_q) begin
          sample_cmp_c = 1'b1;
          advance_c    = 1'b1;
        end else begin
          sample_stream_c = 1'b1;
          state_nx        = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_valid && out_ready) begin
          advance_c = 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (advance_c) begin
      state_nx = last_pat_c ? S_DONE : S_SETTLE;
    end
  end

  // Pattern counter, settle timer and latched mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pi         <= '0;
      settle_cnt <= '0;
      mode_q     <= 1'b0;
    end else begin
      if (load_start_c) begin
        pi         <= '0;
        mode_q     <= mode;
        settle_cnt <= CNT_W'(SETTLE);
      end else if (advance_c && !last_pat_c) begin
        pi         <= pi + N_IN'(1);
        settle_cnt <= CNT_W'(SETTLE);
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt - CNT_W'(1);
      end
    end
  end

  // Stream beat payload, captured once per pattern so it is stable under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pattern <= '0;
      out_value   <= '0;
    end else if (sample_stream_c) begin
      out_pattern <= pi;
      out_value   <= po_dut;
    end
  end

  // Error accumulators; cleared on start, held after the sweep ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count   <= '0;
      err_hd_max  <= '0;
      err_abs_sum <= '0;
    end else if (load_start_c) begin
      err_count   <= '0;
      err_hd_max  <= '0;
      err_abs_sum <= '0;
    end else if (sample_cmp_c) begin
      if (diff_c != '0) begin
        err_count <= err_count + ERR_W'(1);
      end
      if (hd_c > err_hd_max) begin
        err_hd_max <= hd_c;
      end
      err_abs_sum <= err_abs_sum + SUM_W'(abs_diff_c);
    end
  end

  // Status outputs registered from the next state so they align with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= (state_nx == S_EMIT);
      busy      <= (state_nx == S_SETTLE) || (state_nx == S_SAMPLE) || (state_nx == S_EMIT);
      done      <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with default parameters and a
// nibble-adder as the swept combinational block.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] pi;
  logic [4:0] po_dut;
  logic [4:0] po_ref;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pattern;
  logic [4:0] out_value;
  logic       busy;
  logic       done;
  logic [8:0] err_count;
  logic [2:0] err_hd_max;
  logic [12:0] err_abs_sum;
  logic       ref_flip;

  int n_cmp;
  int n_err;

  // Results of the most recent sweep
  int         beats;
  int         cycles;
  int         order_err;
  int         busy_low;
  int         stall_err;
  int         stall_cnt;
  int         extra;
  logic       busy_at_done;
  logic       done_next;
  logic       finished;
  logic [4:0] first_val;
  logic [4:0] last_val;

  truth_table_sweeper dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .pi          (pi),
    .po_dut      (po_dut),
    .po_ref      (po_ref),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pattern (out_pattern),
    .out_value   (out_value),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .err_hd_max  (err_hd_max),
    .err_abs_sum (err_abs_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Swept block: sum of the two nibbles; reference optionally flips bit 0 on odd patterns
  assign po_dut = 5'(pi[7:4]) + 5'(pi[3:0]);
  assign po_ref = (ref_flip && pi[0]) ? (po_dut ^ 5'b00001) : po_dut;

  function automatic logic [4:0] exp_val(input int p);
    logic [7:0] b;
    b = 8'(p);
    return 5'(b[7:4]) + 5'(b[3:0]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Run one sweep from a start pulse to the done pulse; optional stall and start poke
  task automatic sweep(input logic m, input int stall_at, input int poke_at);
    int   stall_left;
    bit   stalled;
    bit   poked;
    logic [4:0] held;
    beats = 0; order_err = 0; busy_low = 0; stall_err = 0; stall_cnt = 0;
    extra = 0; first_val = 5'h1f; last_val = 5'h1f;
    stall_left = 0; stalled = 0; poked = 0; held = '0;
    start = 1'b1; mode = m; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
    cycles = 1;
    while (!done && cycles < 3000) begin
      if (!busy) busy_low++;
      if (poke_at >= 0 && !poked && pi == 8'(poke_at)) begin
        start = 1'b1; poked = 1;
      end else begin
        start = 1'b0;
      end
      if (stall_at >= 0 && !stalled && out_valid && out_pattern == 8'(stall_at)) begin
        stalled = 1; stall_left = 5; held = out_value;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        if (!(out_valid && out_pattern == 8'(stall_at) && pi == 8'(stall_at) && out_value == held))
          stall_err++;
        stall_cnt++;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (out_pattern != 8'(beats) || out_value != exp_val(beats)) order_err++;
        if (beats == 0) first_val = out_value;
        last_val = out_value;
        beats++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    finished = done;
    busy_at_done = busy;
    start = (poke_at >= 0) ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    done_next = done;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) extra++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b1; ref_flip = 1'b0;
    #3;
    check("rst_pi",          32'(pi), 32'd0);
    check("rst_out_valid",   32'(out_valid), 32'd0);
    check("rst_busy",        32'(busy), 32'd0);
    check("rst_done",        32'(done), 32'd0);
    check("rst_out_pattern", 32'(out_pattern), 32'd0);
    check("rst_out_value",   32'(out_value), 32'd0);
    check("rst_err_count",   32'(err_count), 32'd0);
    check("rst_err_abs_sum", 32'(err_abs_sum), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain stream sweep
    sweep(1'b0, -1, -1);
    check("s0_done_seen",   32'(finished), 32'd1);
    check("s0_beats",       32'(beats), 32'd256);
    check("s0_order",       32'(order_err), 32'd0);
    check("s0_first_val",   32'(first_val), 32'd0);
    check("s0_last_val",    32'(last_val), 32'b11110);
    check("s0_cycles",      32'(cycles), 32'(256 * 3 + 1));
    check("s0_busy_low",    32'(busy_low), 32'd0);
    check("s0_busy_done",   32'(busy_at_done), 32'd0);
    check("s0_done_width",  32'(done_next), 32'd0);
    check("s0_after",       32'(extra), 32'd0);

    // Backpressure at pattern 0x03
    sweep(1'b0, 3, -1);
    check("bp_done_seen",   32'(finished), 32'd1);
    check("bp_stall_err",   32'(stall_err), 32'd0);
    check("bp_stall_cnt",   32'(stall_cnt), 32'd5);
    check("bp_beats",       32'(beats), 32'd256);
    check("bp_order",       32'(order_err), 32'd0);
    check("bp_cycles",      32'(cycles), 32'(256 * 3 + 1 + 5));

    // Compare mode, reference equal
    ref_flip = 1'b0;
    sweep(1'b1, -1, -1);
    check("c0_done_seen",   32'(finished), 32'd1);
    check("c0_beats",       32'(beats), 32'd0);
    check("c0_cycles",      32'(cycles), 32'(256 * 2 + 1));
    check("c0_err_count",   32'(err_count), 32'd0);
    check("c0_err_hd_max",  32'(err_hd_max), 32'd0);
    check("c0_err_abs_sum", 32'(err_abs_sum), 32'd0);

    // Compare mode, reference bit 0 flipped on odd patterns
    ref_flip = 1'b1;
    sweep(1'b1, -1, -1);
    check("c1_done_seen",   32'(finished), 32'd1);
    check("c1_err_count",   32'(err_count), 32'd128);
    check("c1_err_hd_max",  32'(err_hd_max), 32'd1);
    check("c1_err_abs_sum", 32'(err_abs_sum), 32'd128);
    ref_flip = 1'b0;
    check("c1_hold_count",  32'(err_count), 32'd128);

    // Reset mid-sweep at pattern 0x40
    start = 1'b1; mode = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (pi != 8'h40 && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("ra_reached_40",  32'(pi), 32'h40);
    #1;
    rst = 1'b1;
    #1;
    check("ra_pi",          32'(pi), 32'd0);
    check("ra_out_valid",   32'(out_valid), 32'd0);
    check("ra_out_pattern", 32'(out_pattern), 32'd0);
    check("ra_busy",        32'(busy), 32'd0);
    check("ra_done",        32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy || out_valid) extra++;
      @(posedge clk); #1;
    end
    check("ra_quiet",       32'(extra), 32'd0);
    sweep(1'b0, -1, -1);
    check("ra_beats",       32'(beats), 32'd256);
    check("ra_order",       32'(order_err), 32'd0);

    // Start pokes while busy (at 0x10) and during DONE
    sweep(1'b0, -1, 16);
    check("pk_done_seen",   32'(finished), 32'd1);
    check("pk_beats",       32'(beats), 32'd256);
    check("pk_order",       32'(order_err), 32'd0);
    check("pk_cycles",      32'(cycles), 32'(256 * 3 + 1));
    check("pk_after",       32'(extra), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
